// File: rtl/tff_counter_bank.sv
// Bank of WIDTH toggle flip-flops: per-bit toggle, parallel load, up/down count.
// Counting uses T-flip-flop chain toggles; wrap pulses for one cycle on each boundary event.
module tff_counter_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           SATURATE  = 0,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_t,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qbar,
    output logic             o_at_max,
    output logic             o_at_min,
    output logic             o_wrap
);

    localparam logic [1:0] ModeToggle = 2'b00;
    localparam logic [1:0] ModeLoad   = 2'b01;
    localparam logic [1:0] ModeUp     = 2'b10;
    localparam logic [1:0] ModeDown   = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_q_d;
    logic             r_wrap;
    logic             r_wrap_d;
    logic [WIDTH-1:0] w_up_tog;
    logic [WIDTH-1:0] w_down_tog;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = &r_q;
    assign w_at_min = ~|r_q;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
    always_comb begin
        logic v_up_carry;
        logic v_down_carry;
        v_up_carry   = 1'b1;
        v_down_carry = 1'b1;
        w_up_tog     = '0;
        w_down_tog   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_up_tog[i]   = v_up_carry;
            w_down_tog[i] = v_down_carry;
            v_up_carry    = v_up_carry & r_q[i];
            v_down_carry  = v_down_carry & ~r_q[i];
        end
    end

    always_comb begin
        r_q_d    = r_q;
        r_wrap_d = 1'b0;
        if (i_en) begin
            unique case (i_mode)
                ModeToggle: r_q_d = r_q ^ i_t;
                ModeLoad:   r_q_d = i_d;
                ModeUp: begin
                    if (w_at_max) begin
                        r_wrap_d = 1'b1;
                        if (SATURATE == 0) r_q_d = r_q ^ w_up_tog;
                    end else begin
                        r_q_d = r_q ^ w_up_tog;
                    end
                end
                ModeDown: begin
                    if (w_at_min) begin
                        r_wrap_d = 1'b1;
                        if (SATURATE == 0) r_q_d = r_q ^ w_down_tog;
                    end else begin
                        r_q_d = r_q ^ w_down_tog;
                    end
                end
                default: r_q_d = r_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= r_q_d;
            r_wrap <= r_wrap_d;
        end
    end

    assign o_q      = r_q;
    assign o_qbar   = ~r_q;
    assign o_at_max = w_at_max;
    assign o_at_min = w_at_min;
    assign o_wrap   = r_wrap;

endmodule

// File: doc/tff_counter_bank.md
# tff_counter_bank

Parametrised bank of WIDTH toggle flip-flops with a synchronous active-low reset and four modes: per-bit toggle, parallel load, up-count and down-count. Up/down counting uses T-flip-flop chain semantics: a bit toggles when all lower bits are 1 (up) or 0 (down). The block succeeds the single-bit toggle flip-flop and serves as the general counter/toggle register for the lab designs, with wrap or saturate behaviour and a boundary-event flag.

## Interface
- WIDTH, 8: number of flip-flops / counter width (≥1).
- SATURATE, 0: 0 = counting wraps at the boundaries; 1 = counting holds at the boundaries.
- RESET_VAL, 0: value loaded into q on reset (WIDTH bits).

- clk  input  1  rising-edge clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-low reset, sampled on posedge clk.
- en  input  1  operation enable; low = hold all state.
- mode  input  2  00 TOGGLE, 01 LOAD, 10 UP, 11 DOWN.
- t  input  WIDTH  per-bit toggle enables (TOGGLE mode only).
- d  input  WIDTH  parallel load data (LOAD mode only).
- q  output  WIDTH  registered flip-flop state.
- qbar  output  WIDTH  ~q, combinational.
- at_max  output  1  combinational; high when q is all ones.
- at_min  output  1  combinational; high when q is all zeros.
- wrap  output  1  registered one-cycle boundary-event pulse (see Operation).

## Operation
- Reset (reset==0 at posedge): q <= RESET_VAL, wrap <= 0. Overrides en and mode.
- en==0: q holds; wrap <= 0.
- en==1, by mode:
  - TOGGLE: q <= q ^ t. Bits with t=0 hold. wrap <= 0.
  - LOAD: q <= d. wrap <= 0.
  - UP: bit i toggles when q[i-1:0] is all ones (bit 0 always toggles), i.e. q <= q+1 mod 2^WIDTH.
    - SATURATE=0: at q = all ones, q becomes 0 and wrap <= 1.
    - SATURATE=1: at q = all ones, q holds and wrap <= 1.
    - Otherwise wrap <= 0.
  - DOWN: bit i toggles when q[i-1:0] is all zeros (bit 0 always toggles), i.e. q <= q-1 mod 2^WIDTH.
    - SATURATE=0: at q = 0, q becomes all ones and wrap <= 1.
    - SATURATE=1: at q = 0, q holds and wrap <= 1.
    - Otherwise wrap <= 0.
- wrap is high for exactly one cycle per boundary event. A sustained UP at saturation re-asserts wrap every enabled cycle.
- t and d are ignored outside their own modes.
- No internal FSM beyond the mode decode. State is q plus wrap.

## Timing
- Latency: 1 clock from sampled inputs to q and wrap. qbar, at_max and at_min follow q combinationally in the same cycle.
- Reset value: q = RESET_VAL, qbar = ~RESET_VAL, wrap = 0; at_max and at_min are derived from RESET_VAL.
- Reset mid-count takes effect at the next posedge regardless of en or mode; any pending wrap is cleared.
- A mode change takes effect on the first posedge at which it is sampled; there are no pipeline hazards.
- Reset is only sampled at clock edges; there is no asynchronous path. Before the first posedge with reset low, q is unknown. The bench must apply reset before checking outputs.
- WIDTH=1: UP and DOWN both toggle the single bit. wrap fires on 1→0 for UP and 0→1 for DOWN when SATURATE=0.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'h5, reset=0 for 2 cycles with en=1, mode=UP -> q=4'h5, qbar=4'hA, wrap=0. Release reset, then 1 cycle UP -> q=4'h6.
- TOGGLE: q=4'h0, en=1, mode=00, t=4'b1010 for 3 cycles -> q=4'hA, 4'h0, 4'hA. With en=0 and t=4'hF -> q holds 4'hA.
- LOAD then UP wrap, SATURATE=0: load d=4'hE, then UP for 3 cycles -> q=4'hF, 4'h0, 4'h1. wrap is high only in the cycle q shows 4'h0. at_max is high while q=4'hF.
- DOWN wrap and saturate: SATURATE=0, load 4'h1, DOWN ×2 -> q=4'h0, then 4'hF with wrap=1. With SATURATE=1, same stimulus -> q=4'h0, then 4'h0 with wrap=1, and wrap stays 1 on each further DOWN cycle.
- Reset mid-count: UP counting from 4'h3; assert reset=0 in the cycle q=4'h7 with mode=UP and en=1 -> next q=RESET_VAL and wrap=0. Counting resumes from RESET_VAL after release.
- Mode switch: UP to q=4'h8, switch to DOWN on the next cycle -> q=4'h7. Switch to TOGGLE with t=4'h1 -> q=4'h6. No wrap pulse throughout.
